// File: rtl/bpsk_bit_framer_if.sv
// Byte stream handshake into the BPSK bit framer.
// The source drives data_in/data_valid; the framer answers with data_ready.
interface bpsk_bit_framer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/bpsk_bit_framer.sv
// BPSK bit framer: takes bytes from a valid/ready stream, adds an alternating
// preamble per burst and serialises data MSB-first onto the phase bit.
// A one-byte holding register allows back-to-back bytes with no gap.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no burst; waits for en & a held byte, phase keeps last value
// PREAMBLE | sending 1,0,1,0,... preamble bits
// DATA     | shifting out the loaded byte; reloads from hold if a byte waits
module bpsk_bit_framer #(
  parameter int SAMPLES_PER_SYMBOL = 64,
  parameter int PREAMBLE_LEN       = 8,
  parameter int DIFF_ENC           = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  bpsk_bit_framer_if.slave     s_if,
  output logic                 phase,
  output logic                 carrier_en,
  output logic                 sym_strobe,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLES_PER_SYMBOL);
  // A zero-length preamble still needs a legal one-bit counter.
  localparam int PW = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
  localparam logic [CW-1:0] SYM_LAST = CW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   sym_cnt_q, sym_cnt_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  // Bits still to send after the one currently on phase, next bit in [6].
  logic [6:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            phase_q, phase_d;
  logic            strobe_q, strobe_d;

  logic            accept;
  logic            boundary;
  logic            start_bit;
  logic            bit_val;
  logic            load;

  assign accept   = s_if.data_valid & ~hold_full_q;
  assign boundary = en & (state_q != IDLE) & (sym_cnt_q == SYM_LAST);

  // Next-state logic: handshake, symbol timer, FSM and phase update.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    start_bit   = 1'b0;
    bit_val     = 1'b0;
    load        = 1'b0;

    if (accept) begin
      hold_d      = s_if.data_in;
      hold_full_d = 1'b1;
    end

    if (en && (state_q != IDLE)) begin
      sym_cnt_d = boundary ? '0 : sym_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en && hold_full_q) begin
          start_bit = 1'b1;
          if (PREAMBLE_LEN > 0) begin
            state_d   = PREAMBLE;
            pre_cnt_d = '0;
            bit_val   = 1'b1;
          end else begin
            state_d = DATA;
            load    = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (boundary) begin
          start_bit = 1'b1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d = DATA;
            load    = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
            // Next index is k+1, whose bit ~(k+1)[0] equals k[0].
            bit_val   = pre_cnt_q[0];
          end
        end
      end
      DATA: begin
        if (boundary) begin
          if (bit_cnt_q == 3'd7) begin
            if (hold_full_q) begin
              start_bit = 1'b1;
              load      = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            start_bit = 1'b1;
            bit_val   = shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load never coincides with accept: ready is low while hold is full.
    if (load) begin
      bit_val     = hold_q[7];
      shift_d     = hold_q[6:0];
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
    end

    if (start_bit) begin
      phase_d = (DIFF_ENC != 0) ? (phase_q ^ bit_val) : bit_val;
    end else begin
      phase_d = phase_q;
    end
    strobe_d = start_bit;
  end

  // State registers; async reset aborts any burst and drops the held byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      phase_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      phase_q     <= phase_d;
      strobe_q    <= strobe_d;
    end
  end

  assign s_if.data_ready = ~hold_full_q;
  assign phase           = phase_q;
  assign sym_strobe      = strobe_q;
  assign carrier_en      = en & (state_q != IDLE);
  assign busy            = (state_q != IDLE) | hold_full_q;

endmodule
